spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on spi_cs, spi_clk and spi_mosi (minimum 2).
REQ-002 SHALL have port raw_clk  input  1  the only clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  bus select; a read occurs when enable=1 and write_enable=0.
REQ-005 SHALL have port address  input  2  register select.
REQ-006 SHALL have port data_in  input  16  write data; only bits [7:0] are used.
REQ-007 SHALL have port data_out  output  16  registered read data.
REQ-008 SHALL have port write_enable  input  1  write strobe, one raw_clk cycle per write.
REQ-009 SHALL have port spi_cs  input  1  chip select from the external master, active low.
REQ-010 SHALL have port spi_clk  input  1  SCLK from the external master, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port spi_mosi  input  1  serial data from the master, MSB first.
REQ-012 SHALL have port spi_miso  output  1  serial data to the master, MSB first.
REQ-013 SHALL have port rx_ready  output  1  copy of the rx_valid flag, usable as an interrupt.

Function
REQ-014 SHALL define the register map as:
- 0: read-only status {14'b0, overrun, rx_valid}.
- 1: read/write tx_buffer[7:0].
- 2: read rx_buffer[7:0]; the read clears rx_valid.
- 3: write-only; writing data_in[0]=1 clears overrun; reads return 0.
REQ-015 SHALL update data_out on the raw_clk edge of each read and hold it otherwise; upper bits are zero.
REQ-016 SHALL pass spi_cs, spi_clk and spi_mosi through SYNC_STAGES flops, then one further edge-detect flop; all SPI logic acts on the synchronized versions.
REQ-017 SHALL run a two-state FSM:
- IDLE to ACTIVE on a detected falling edge of spi_cs.
- ACTIVE to IDLE on a detected rising edge of spi_cs.
REQ-018 SHALL, on entering ACTIVE, set bit_count=0, load tx_shift from tx_buffer, and drive spi_miso from tx_buffer[7] in the same cycle.
REQ-019 SHALL, on each detected SCLK rising edge in ACTIVE, shift the synchronized MOSI into rx_shift LSB and increment the 3-bit bit_count.
REQ-020 SHALL, on each detected SCLK falling edge in ACTIVE, shift tx_shift left and drive its new MSB onto spi_miso.
REQ-021 SHALL, on the 8th rising edge (bit_count 7 to 0 wrap), write the completed byte to rx_buffer and set rx_valid, in the same cycle as the 8th shift.
REQ-022 SHALL set rx_valid exactly SYNC_STAGES+1 raw_clk cycles after the first raw_clk edge that samples the 8th SCLK rise.
REQ-023 SHALL, on the falling edge that follows a byte completion, reload tx_shift from tx_buffer instead of shifting, so back-to-back bytes require no CS toggle.
REQ-024 SHALL, when a byte completes while rx_valid=1 and no rx_buffer read occurs in that cycle, overwrite rx_buffer and set overrun.
REQ-025 SHALL, when a byte completes in the same cycle as an rx_buffer read, return the old byte to the read, leave rx_valid=1, and leave overrun unchanged.
REQ-026 SHALL, when a tx_buffer write coincides with a reload, load the new data_in[7:0].
REQ-027 SHALL, when CS rises mid-byte, discard the partial byte, clear bit_count, leave rx_valid and rx_buffer unchanged, and return to IDLE.
REQ-028 SHALL ignore SCLK and MOSI activity in IDLE.
REQ-029 SHALL drive spi_miso=0 in IDLE.
REQ-030 SHALL operate correctly for SCLK frequencies up to raw_clk/8 with each SCLK phase at least 4 raw_clk cycles.

Reset
REQ-031 SHALL, while reset=1, asynchronously force:
- FSM to IDLE.
- tx_buffer, rx_buffer, tx_shift, rx_shift, bit_count and data_out to 0.
- rx_valid, overrun, spi_miso, rx_ready and all synchronizer flops to 0, except the spi_cs synchronizers, which are forced to 1.
REQ-032 SHALL, when reset asserts mid-transfer, abort the transfer and require a fresh CS falling edge after reset release before shifting resumes.

Verification
REQ-033 SHALL cover: tx_buffer=0xA5; master sends 0x3C with SCLK=raw_clk/8 -> master receives 0xA5, status=0x0001, rx_buffer read=0x003C, then status=0x0000.
REQ-034 SHALL cover: tx_buffer=0x81; master clocks two bytes 0x11, 0x22 without raising CS and without an rx read -> MISO bytes 0x81, 0x81; rx_buffer=0x22; status=0x0003; write 1 to addr 3 -> status=0x0001.
REQ-035 SHALL cover: CS low, 5 SCLK pulses, CS high -> rx_valid stays 0; the next full byte 0xF0 is received correctly.
REQ-036 SHALL cover: 2nd byte completion in the same cycle as an rx_buffer read -> read returns the 1st byte, rx_valid=1, overrun=0.
REQ-037 SHALL cover: reset pulsed after 4 bits of a transfer -> all registers read 0 and spi_miso=0; SCLK activity is ignored until a new CS fall, then byte 0x5A is received intact.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave with a 4-entry register interface on raw_clk.
// SPI pins are oversampled: synchronizer chain, edge-detect flop, registered edge pulses.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        write_enable,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        rx_ready
);

  typedef enum logic {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, clk_sync_q, mosi_sync_q;
  logic                   cs_s, clk_s, mosi_s;
  logic                   cs_e_q, clk_e_q, mosi_e_q;
  logic                   cs_fall_q, cs_rise_q, sclk_rise_q, sclk_fall_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   armed_q, armed_d;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        miso_q, miso_d;
  logic        reload_q, reload_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic [15:0] data_out_q, data_out_d;

  logic        wr, rd, rd_rx, byte_done;
  logic [7:0]  tx_next, rx_byte;
  logic        unused_data_hi;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign unused_data_hi = ^data_in[15:8];

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      cs_sync_q   <= '1;
      clk_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_e_q      <= 1'b1;
      clk_e_q     <= 1'b0;
      mosi_e_q    <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_e_q      <= cs_s;
      clk_e_q     <= clk_s;
      mosi_e_q    <= mosi_s;
      cs_fall_q   <= cs_e_q & ~cs_s;
      cs_rise_q   <= ~cs_e_q & cs_s;
      sclk_rise_q <= ~clk_e_q & clk_s;
      sclk_fall_q <= clk_e_q & ~clk_s;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  // The CS chain resets high, so a CS held low across reset would look like a fresh
  // falling edge. Only honour falls once real CS-high has been seen after the flush.
  always_comb begin
    armed_d = armed_q;
    if (flush_q[SYNC_STAGES] && cs_e_q) begin
      armed_d = 1'b1;
    end
  end

  assign wr      = enable & write_enable;
  assign rd      = enable & ~write_enable;
  assign rd_rx   = rd && (address == 2'd2);
  assign tx_next = (wr && (address == 2'd1)) ? data_in[7:0] : tx_buf_q;
  assign rx_byte = {rx_shift_q[6:0], mosi_e_q};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    reload_d   = reload_q;
    byte_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        miso_d    = 1'b0;
        bit_cnt_d = 3'd0;
        reload_d  = 1'b0;
        if (cs_fall_q && armed_q) begin
          state_d    = StActive;
          tx_shift_d = tx_next;
          miso_d     = tx_next[7];
        end
      end
      StActive: begin
        if (cs_rise_q) begin
          state_d    = StIdle;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'd0;
          miso_d     = 1'b0;
          reload_d   = 1'b0;
        end else if (sclk_rise_q) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            reload_d  = 1'b1;
          end
        end else if (sclk_fall_q) begin
          if (reload_q) begin
            tx_shift_d = tx_next;
            miso_d     = tx_next[7];
            reload_d   = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            miso_d     = tx_shift_q[6];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_buf_d   = tx_next;
    rx_buf_d   = rx_buf_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    data_out_d = data_out_q;

    if (wr && (address == 2'd3) && data_in[0]) begin
      overrun_d = 1'b0;
    end

    // A read racing a completion gets the old byte and does not count as an overrun.
    if (byte_done) begin
      rx_buf_d   = rx_byte;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_rx) begin
        overrun_d = 1'b1;
      end
    end else if (rd_rx) begin
      rx_valid_d = 1'b0;
    end

    if (rd) begin
      unique case (address)
        2'd0:    data_out_d = {14'd0, overrun_q, rx_valid_q};
        2'd1:    data_out_d = {8'd0, tx_buf_q};
        2'd2:    data_out_d = {8'd0, rx_buf_q};
        default: data_out_d = 16'd0;
      endcase
    end
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= 8'd0;
      rx_shift_q <= 8'd0;
      miso_q     <= 1'b0;
      reload_q   <= 1'b0;
      tx_buf_q   <= 8'd0;
      rx_buf_q   <= 8'd0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      data_out_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      reload_q   <= reload_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign spi_miso = miso_q;
  assign rx_ready = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: bit-banged mode-0 master plus a byte-level register model.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic        raw_clk = 1'b0;
  logic        reset, enable, write_enable;
  logic [1:0]  address;
  logic [15:0] data_in, data_out;
  logic        spi_cs, spi_clk, spi_mosi, spi_miso, rx_ready;

  int total = 0;
  int bad   = 0;

  // Byte-level model of the register file.
  logic [7:0] m_tx, m_rx;
  logic       m_valid, m_ovr;

  always #5 raw_clk = ~raw_clk;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .raw_clk     (raw_clk),
    .reset       (reset),
    .enable      (enable),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .write_enable(write_enable),
    .spi_cs      (spi_cs),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .rx_ready    (rx_ready)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge raw_clk);
    enable = 1'b1; write_enable = 1'b1; address = a; data_in = d;
    @(negedge raw_clk);
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge raw_clk);
    enable = 1'b1; write_enable = 1'b0; address = a;
    @(negedge raw_clk);
    enable = 1'b0;
    d = data_out;
  endtask

  task automatic cs_fall();
    @(negedge raw_clk);
    spi_cs = 1'b0;
    repeat (HALF) @(negedge raw_clk);
  endtask

  task automatic cs_rise();
    repeat (HALF) @(negedge raw_clk);
    spi_cs = 1'b1;
    repeat (2 * HALF) @(negedge raw_clk);
  endtask

  task automatic sclk_pulse(input logic mo);
    spi_mosi = mo;
    repeat (HALF) @(negedge raw_clk);
    spi_clk = 1'b1;
    repeat (HALF) @(negedge raw_clk);
    spi_clk = 1'b0;
  endtask

  // One master byte; optionally issues an rx_buffer read timed to land on the completion cycle.
  task automatic spi_byte(input logic [7:0] mo, input logic rd_at_end, output logic [7:0] mi,
                          output logic [15:0] rd_data, output logic [3:0] rdy_tr);
    mi = 8'd0; rd_data = 16'd0; rdy_tr = 4'd0;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = mo[7-i];
      repeat (HALF) @(negedge raw_clk);
      mi[7-i] = spi_miso;
      spi_clk = 1'b1;
      for (int j = 0; j < HALF; j++) begin
        @(negedge raw_clk);
        if (i == 7) rdy_tr[j] = rx_ready;
        if (i == 7 && rd_at_end && j == SYNC) begin
          enable = 1'b1; write_enable = 1'b0; address = 2'd2;
        end
        if (i == 7 && rd_at_end && j == SYNC + 1) begin
          rd_data = data_out;
          enable = 1'b0;
        end
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic rd, output logic [7:0] exp_rd);
    exp_rd = m_rx;
    if (!rd && m_valid) m_ovr = 1'b1;
    m_rx    = b;
    m_valid = 1'b1;
  endtask

  task automatic model_reset();
    m_tx = 8'd0; m_rx = 8'd0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b1; enable = 1'b0; write_enable = 1'b0; address = 2'd0; data_in = 16'd0;
    spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge raw_clk);
    total++;
    if (data_out !== 16'd0 || spi_miso !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got data_out=%h miso=%b rdy=%b want 0000 0 0",
               data_out, spi_miso, rx_ready);
    end
    reset = 1'b0;
    repeat (8) @(negedge raw_clk);
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d);
      total++;
      if (d !== 16'd0) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h want 0000", a, d);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] mi, er; logic [15:0] d, rdd; logic [3:0] tr;
    m_tx = 8'hA5;
    bus_write(2'd1, {8'd0, m_tx});
    bus_read(2'd1, d);
    total++;
    if (d !== {8'd0, m_tx}) begin bad++; $display("FAIL basic_txread: got %h want %h", d, m_tx); end
    cs_fall();
    spi_byte(8'h3C, 1'b0, mi, rdd, tr);
    model_byte(8'h3C, 1'b0, er);
    cs_rise();
    total++;
    if (mi !== m_tx) begin bad++; $display("FAIL basic_miso: got %h want %h", mi, m_tx); end
    // rx_valid rises SYNC+1 edges after the edge that samples SCLK high.
    total++;
    if (tr !== 4'b1000) begin bad++; $display("FAIL basic_latency: got %b want 1000", tr); end
    bus_read(2'd0, d);
    total++;
    if (d !== {14'd0, m_ovr, m_valid}) begin
      bad++; $display("FAIL basic_status: got %h want %h", d, {14'd0, m_ovr, m_valid});
    end
    bus_read(2'd2, d);
    total++;
    if (d !== {8'd0, m_rx}) begin bad++; $display("FAIL basic_rx: got %h want %h", d, m_rx); end
    m_valid = 1'b0;
    bus_read(2'd0, d);
    total++;
    if (d !== 16'd0) begin bad++; $display("FAIL basic_status_clr: got %h want 0000", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2, er; logic [15:0] d, rdd; logic [3:0] tr;
    m_tx = 8'h81;
    bus_write(2'd1, {8'd0, m_tx});
    cs_fall();
    spi_byte(8'h11, 1'b0, mi1, rdd, tr);
    model_byte(8'h11, 1'b0, er);
    spi_byte(8'h22, 1'b0, mi2, rdd, tr);
    model_byte(8'h22, 1'b0, er);
    cs_rise();
    total++;
    if (mi1 !== m_tx || mi2 !== m_tx) begin
      bad++; $display("FAIL b2b_miso: got %h %h want %h %h", mi1, mi2, m_tx, m_tx);
    end
    bus_read(2'd0, d);
    total++;
    if (d !== {14'd0, m_ovr, m_valid}) begin
      bad++; $display("FAIL b2b_status: got %h want %h", d, {14'd0, m_ovr, m_valid});
    end
    bus_read(2'd3, d);
    total++;
    if (d !== 16'd0) begin bad++; $display("FAIL b2b_addr3: got %h want 0000", d); end
    bus_write(2'd3, 16'h0001);
    m_ovr = 1'b0;
    bus_read(2'd0, d);
    total++;
    if (d !== {14'd0, m_ovr, m_valid}) begin
      bad++; $display("FAIL b2b_ovr_clr: got %h want %h", d, {14'd0, m_ovr, m_valid});
    end
    bus_read(2'd2, d);
    m_valid = 1'b0;
    total++;
    if (d !== {8'd0, m_rx}) begin bad++; $display("FAIL b2b_rx: got %h want %h", d, m_rx); end
  endtask

  task automatic test_abort();
    logic [7:0] mi, er; logic [15:0] d, rdd; logic [3:0] tr;
    cs_fall();
    for (int k = 0; k < 5; k++) sclk_pulse(1'($urandom));
    cs_rise();
    bus_read(2'd0, d);
    total++;
    if (d !== {14'd0, m_ovr, m_valid}) begin
      bad++; $display("FAIL abort_status: got %h want %h", d, {14'd0, m_ovr, m_valid});
    end
    cs_fall();
    spi_byte(8'hF0, 1'b0, mi, rdd, tr);
    model_byte(8'hF0, 1'b0, er);
    cs_rise();
    total++;
    if (mi !== m_tx) begin bad++; $display("FAIL abort_miso: got %h want %h", mi, m_tx); end
    bus_read(2'd2, d);
    m_valid = 1'b0;
    total++;
    if (d !== {8'd0, m_rx}) begin bad++; $display("FAIL abort_rx: got %h want %h", d, m_rx); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] b1, b2, mi, er; logic [15:0] d, rdd; logic [3:0] tr;
    b1 = 8'($urandom); b2 = 8'($urandom);
    m_tx = 8'($urandom);
    bus_write(2'd1, {8'd0, m_tx});
    cs_fall();
    spi_byte(b1, 1'b0, mi, rdd, tr);
    model_byte(b1, 1'b0, er);
    spi_byte(b2, 1'b1, mi, rdd, tr);
    model_byte(b2, 1'b1, er);
    cs_rise();
    total++;
    if (rdd !== {8'd0, er}) begin bad++; $display("FAIL race_read: got %h want %h", rdd, er); end
    bus_read(2'd0, d);
    total++;
    if (d !== {14'd0, m_ovr, m_valid}) begin
      bad++; $display("FAIL race_status: got %h want %h", d, {14'd0, m_ovr, m_valid});
    end
    bus_read(2'd2, d);
    m_valid = 1'b0;
    total++;
    if (d !== {8'd0, m_rx}) begin bad++; $display("FAIL race_rx: got %h want %h", d, m_rx); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, er; logic [15:0] d, rdd; logic [3:0] tr; logic miso_seen;
    m_tx = 8'($urandom) | 8'h80;
    bus_write(2'd1, {8'd0, m_tx});
    cs_fall();
    for (int k = 0; k < 4; k++) sclk_pulse(1'($urandom));
    @(negedge raw_clk);
    reset = 1'b1;
    repeat (2) @(negedge raw_clk);
    model_reset();
    total++;
    if (data_out !== 16'd0 || spi_miso !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got data_out=%h miso=%b rdy=%b want 0000 0 0",
               data_out, spi_miso, rx_ready);
    end
    reset = 1'b0;
    miso_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      spi_mosi = 1'($urandom);
      repeat (HALF) @(negedge raw_clk);
      miso_seen |= spi_miso;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge raw_clk);
      miso_seen |= spi_miso;
      spi_clk = 1'b0;
    end
    total++;
    if (miso_seen !== 1'b0) begin bad++; $display("FAIL midreset_miso: got 1 want 0"); end
    for (int a = 0; a < 3; a++) begin
      bus_read(a[1:0], d);
      total++;
      if (d !== 16'd0) begin bad++; $display("FAIL midreset_reg%0d: got %h want 0000", a, d); end
    end
    cs_rise();
    cs_fall();
    spi_byte(8'h5A, 1'b0, mi, rdd, tr);
    model_byte(8'h5A, 1'b0, er);
    cs_rise();
    total++;
    if (mi !== m_tx) begin bad++; $display("FAIL midreset_miso2: got %h want %h", mi, m_tx); end
    bus_read(2'd0, d);
    total++;
    if (d !== {14'd0, m_ovr, m_valid}) begin
      bad++; $display("FAIL midreset_status: got %h want %h", d, {14'd0, m_ovr, m_valid});
    end
    bus_read(2'd2, d);
    m_valid = 1'b0;
    total++;
    if (d !== {8'd0, m_rx}) begin bad++; $display("FAIL midreset_rx: got %h want %h", d, m_rx); end
  endtask

  task automatic test_random();
    logic [7:0] mo, mi, er; logic [15:0] d, rdd; logic [3:0] tr; int n;
    for (int it = 0; it < 6; it++) begin
      m_tx = 8'($urandom);
      bus_write(2'd1, {8'd0, m_tx});
      n = int'($urandom_range(1, 3));
      cs_fall();
      for (int k = 0; k < n; k++) begin
        mo = 8'($urandom);
        spi_byte(mo, 1'b0, mi, rdd, tr);
        model_byte(mo, 1'b0, er);
        total++;
        if (mi !== m_tx) begin
          bad++; $display("FAIL rand%0d_miso%0d: got %h want %h", it, k, mi, m_tx);
        end
      end
      cs_rise();
      bus_read(2'd0, d);
      total++;
      if (d !== {14'd0, m_ovr, m_valid}) begin
        bad++; $display("FAIL rand%0d_status: got %h want %h", it, d, {14'd0, m_ovr, m_valid});
      end
      bus_read(2'd2, d);
      m_valid = 1'b0;
      total++;
      if (d !== {8'd0, m_rx}) begin
        bad++; $display("FAIL rand%0d_rx: got %h want %h", it, d, m_rx);
      end
      if (m_ovr) begin
        bus_write(2'd3, 16'h0001);
        m_ovr = 1'b0;
      end
      bus_read(2'd0, d);
      total++;
      if (d !== 16'd0) begin bad++; $display("FAIL rand%0d_idle: got %h want 0000", it, d); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
